// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: mode encodings, funct/opcode values,
// branch condition codes and flag bit positions.
package alu_pkg;

    typedef logic [3:0] alu_mode_t;
    typedef logic [3:0] cond_t;

    localparam alu_mode_t ALU_AND  = 4'b0000;
    localparam alu_mode_t ALU_ADD  = 4'b0001;
    localparam alu_mode_t ALU_SUB  = 4'b0010;
    localparam alu_mode_t ALU_OR   = 4'b0011;
    localparam alu_mode_t ALU_XOR  = 4'b0100;
    localparam alu_mode_t ALU_NOR  = 4'b0101;
    localparam alu_mode_t ALU_SLT  = 4'b0110;
    localparam alu_mode_t ALU_SLTU = 4'b0111;
    localparam alu_mode_t ALU_SLL  = 4'b1000;
    localparam alu_mode_t ALU_SRL  = 4'b1001;
    localparam alu_mode_t ALU_SRA  = 4'b1010;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;

    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_BGTZ = 6'b000111;

    localparam cond_t COND_EQ   = 4'b0000;
    localparam cond_t COND_NE   = 4'b0001;
    localparam cond_t COND_LT   = 4'b0010;
    localparam cond_t COND_GE   = 4'b0011;
    localparam cond_t COND_LE   = 4'b0100;
    localparam cond_t COND_GT   = 4'b0101;
    localparam cond_t COND_NONE = 4'b1111;

    localparam int FLAG_Z   = 0;
    localparam int FLAG_N   = 1;
    localparam int FLAG_C   = 2;
    localparam int FLAG_V   = 3;
    localparam int FLAG_LT  = 4;
    localparam int FLAG_LTU = 5;

    // Only Z and LT are needed by the conditions in use; unknown codes never branch.
    function automatic logic cond_eval(input cond_t cond, input logic z, input logic lt);
        case (cond)
            COND_EQ: cond_eval = z;
            COND_NE: cond_eval = ~z;
            COND_LT: cond_eval = lt;
            COND_GE: cond_eval = ~lt;
            COND_LE: cond_eval = lt | z;
            COND_GT: cond_eval = ~lt & ~z;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU producing the result and an 8-bit flag vector.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  alu_mode_t              mode,
    input  logic [DATA_WIDTH-1:0]  a,
    input  logic [DATA_WIDTH-1:0]  b,
    output logic [DATA_WIDTH-1:0]  result,
    output logic [7:0]             flags
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [SHW-1:0]        shamt;
    logic                  carry;
    logic                  ovf;
    logic                  arith;

    // SUB is a + ~b + 1, so its carry-out is set exactly when there is no borrow.
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} + {1'b0, ~b} + (DATA_WIDTH+1)'(1);
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        arith  = 1'b0;
        case (mode)
            ALU_AND:  result = a & b;
            ALU_ADD: begin
                result = sum[DATA_WIDTH-1:0];
                carry  = sum[DATA_WIDTH];
                ovf    = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                         (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
                arith  = 1'b1;
            end
            ALU_SUB: begin
                result = diff[DATA_WIDTH-1:0];
                carry  = diff[DATA_WIDTH];
                ovf    = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                         (diff[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
                arith  = 1'b1;
            end
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, a < b};
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            default:  result = '0;
        endcase
    end

    always_comb begin
        flags           = '0;
        flags[FLAG_Z]   = (result == '0);
        flags[FLAG_N]   = result[DATA_WIDTH-1];
        flags[FLAG_C]   = carry;
        flags[FLAG_V]   = ovf;
        flags[FLAG_LT]  = arith & (result[DATA_WIDTH-1] ^ ovf);
        flags[FLAG_LTU] = arith & ~carry;
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage core: ALU control decode, ALU, branch/jump analysis and the
// registered flags/branch decision consumed by the next-PC logic.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic [31:0]            inst,
    input  logic [1:0]             alu_op,
    input  logic [DATA_WIDTH-1:0]  a,
    input  logic [DATA_WIDTH-1:0]  b,
    output logic [DATA_WIDTH-1:0]  result,
    output logic [7:0]             flags,
    output logic                   shift,
    output logic                   branch,
    output logic                   jump,
    output logic [3:0]             cond,
    output logic                   take_branch,
    output logic [7:0]             flags_q,
    output logic                   take_branch_q
);

    logic [5:0]  funct;
    logic [5:0]  opcode;
    alu_mode_t   mode;
    logic        unused_inst_bits;

    assign funct            = inst[5:0];
    assign opcode           = inst[31:26];
    assign unused_inst_bits = ^inst[25:6];

    always_comb begin
        mode  = ALU_ADD;
        shift = 1'b0;
        case (alu_op)
            2'b00: mode = ALU_ADD;
            2'b01: mode = ALU_SUB;
            2'b11: mode = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: mode = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: mode = ALU_SUB;
                    FUNCT_AND:  mode = ALU_AND;
                    FUNCT_OR:   mode = ALU_OR;
                    FUNCT_XOR:  mode = ALU_XOR;
                    FUNCT_NOR:  mode = ALU_NOR;
                    FUNCT_SLT:  mode = ALU_SLT;
                    FUNCT_SLTU: mode = ALU_SLTU;
                    FUNCT_SLL: begin mode = ALU_SLL; shift = 1'b1; end
                    FUNCT_SRL: begin mode = ALU_SRL; shift = 1'b1; end
                    FUNCT_SRA: begin mode = ALU_SRA; shift = 1'b1; end
                    default:    mode = ALU_ADD;
                endcase
            end
        endcase
    end

    alu_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu_core (
        .mode   (mode),
        .a      (a),
        .b      (b),
        .result (result),
        .flags  (flags)
    );

    always_comb begin
        branch = 1'b0;
        jump   = 1'b0;
        cond   = COND_NONE;
        case (opcode)
            OP_J, OP_JAL: jump = 1'b1;
            OP_BEQ:  begin branch = 1'b1; cond = COND_EQ; end
            OP_BNE:  begin branch = 1'b1; cond = COND_NE; end
            OP_BLEZ: begin branch = 1'b1; cond = COND_LE; end
            OP_BGTZ: begin branch = 1'b1; cond = COND_GT; end
            default: ;
        endcase
    end

    assign take_branch = branch & ~jump & cond_eval(cond, flags[FLAG_Z], flags[FLAG_LT]);

    // Reset only touches the pipeline copies; the combinational path stays live.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            flags_q       <= '0;
            take_branch_q <= 1'b0;
        end else begin
            flags_q       <= flags;
            take_branch_q <= take_branch;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: table of hand-computed results plus
// reset sequences for the registered flags/branch decision.
module tb_alu_exec_unit;

    logic        CLK = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [1:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [7:0]  flags;
    logic        shift;
    logic        branch;
    logic        jump;
    logic [3:0]  cond;
    logic        take_branch;
    logic [7:0]  flags_q;
    logic        take_branch_q;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  alu_op;
        logic [31:0] inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic [7:0]  flags;
        logic        shift;
        logic        branch;
        logic        jump;
        logic [3:0]  cond;
        logic        take;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    always #5 CLK = ~CLK;

    alu_exec_unit #(.DATA_WIDTH(32)) dut (
        .CLK           (CLK),
        .rst           (rst),
        .inst          (inst),
        .alu_op        (alu_op),
        .a             (a),
        .b             (b),
        .result        (result),
        .flags         (flags),
        .shift         (shift),
        .branch        (branch),
        .jump          (jump),
        .cond          (cond),
        .take_branch   (take_branch),
        .flags_q       (flags_q),
        .take_branch_q (take_branch_q)
    );

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s vec %0d: got %h, want %h", name, idx, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] i,
                                 input logic [31:0] va, input logic [31:0] vb);
        @(negedge CLK);
        alu_op = op;
        inst   = i;
        a      = va;
        b      = vb;
        #1;
    endtask

    initial begin
        //            op     inst          a             b             result        flags  sh br jp cond  tk
        vecs[0]  = '{2'b00, 32'h0000_0000, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 8'h20, 0, 0, 0, 4'hF, 0};
        vecs[1]  = '{2'b10, 32'h0000_0022, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 8'h05, 0, 0, 0, 4'hF, 0};
        vecs[2]  = '{2'b10, 32'h0000_002A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 8'h00, 0, 0, 0, 4'hF, 0};
        vecs[3]  = '{2'b10, 32'h0000_002B, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 8'h01, 0, 0, 0, 4'hF, 0};
        vecs[4]  = '{2'b10, 32'h0000_0003, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 8'h02, 1, 0, 0, 4'hF, 0};
        vecs[5]  = '{2'b00, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 8'h2A, 0, 0, 0, 4'hF, 0};
        vecs[6]  = '{2'b01, 32'h1000_0000, 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 8'h05, 0, 1, 0, 4'h0, 1};
        vecs[7]  = '{2'b01, 32'h1400_0000, 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 8'h05, 0, 1, 0, 4'h1, 0};
        vecs[8]  = '{2'b00, 32'h0800_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 8'h21, 0, 0, 1, 4'hF, 0};
        vecs[9]  = '{2'b10, 32'h0000_0024, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 8'h02, 0, 0, 0, 4'hF, 0};
        vecs[10] = '{2'b10, 32'h0000_0027, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 8'h02, 0, 0, 0, 4'hF, 0};
        vecs[11] = '{2'b10, 32'h0000_0026, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 8'h00, 0, 0, 0, 4'hF, 0};
        vecs[12] = '{2'b10, 32'h0000_0000, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 8'h02, 1, 0, 0, 4'hF, 0};
        vecs[13] = '{2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 8'h00, 1, 0, 0, 4'hF, 0};
        vecs[14] = '{2'b11, 32'h0000_0000, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 8'h00, 0, 0, 0, 4'hF, 0};
        vecs[15] = '{2'b10, 32'h0000_003F, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 8'h05, 0, 0, 0, 4'hF, 0};
        vecs[16] = '{2'b01, 32'h1800_0000, 32'h0000_0002, 32'h0000_0005, 32'hFFFF_FFFD, 8'h32, 0, 1, 0, 4'h4, 1};
        vecs[17] = '{2'b01, 32'h1C00_0000, 32'h0000_0005, 32'h0000_0002, 32'h0000_0003, 8'h04, 0, 1, 0, 4'h5, 1};
        vecs[18] = '{2'b01, 32'h1C00_0000, 32'h0000_0002, 32'h0000_0005, 32'hFFFF_FFFD, 8'h32, 0, 1, 0, 4'h5, 0};
        vecs[19] = '{2'b01, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 8'h1C, 0, 0, 0, 4'hF, 0};
        vecs[20] = '{2'b10, 32'h0000_0021, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'h16, 0, 0, 0, 4'hF, 0};
        vecs[21] = '{2'b01, 32'h0C00_0000, 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 8'h05, 0, 0, 1, 4'hF, 0};

        rst    = 1'b1;
        inst   = 32'h0;
        alu_op = 2'b00;
        a      = 32'h1;
        b      = 32'h1;
        #2;
        checkOutput("reset_flags_q", -1, {24'h0, flags_q}, 32'h0);
        checkOutput("reset_take_q", -1, {31'h0, take_branch_q}, 32'h0);
        @(posedge CLK);
        #1;
        checkOutput("reset_hold_flags_q", -1, {24'h0, flags_q}, 32'h0);
        @(negedge CLK);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].alu_op, vecs[i].inst, vecs[i].a, vecs[i].b);
            checkOutput("result", i, result, vecs[i].result);
            checkOutput("flags", i, {24'h0, flags}, {24'h0, vecs[i].flags});
            checkOutput("shift", i, {31'h0, shift}, {31'h0, vecs[i].shift});
            checkOutput("branch", i, {31'h0, branch}, {31'h0, vecs[i].branch});
            checkOutput("jump", i, {31'h0, jump}, {31'h0, vecs[i].jump});
            checkOutput("cond", i, {28'h0, cond}, {28'h0, vecs[i].cond});
            checkOutput("take_branch", i, {31'h0, take_branch}, {31'h0, vecs[i].take});
            @(posedge CLK);
            #1;
            checkOutput("flags_q", i, {24'h0, flags_q}, {24'h0, vecs[i].flags});
            checkOutput("take_branch_q", i, {31'h0, take_branch_q}, {31'h0, vecs[i].take});
        end

        // Taken beq registered, then reset pulsed mid-cycle with no clock edge.
        applyStimulus(2'b01, 32'h1000_0000, 32'h9, 32'h9);
        @(posedge CLK);
        #1;
        checkOutput("pre_rst_take_q", 100, {31'h0, take_branch_q}, 32'h1);
        checkOutput("pre_rst_flags_q", 100, {24'h0, flags_q}, 32'h05);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_flags_q", 100, {24'h0, flags_q}, 32'h0);
        checkOutput("async_rst_take_q", 100, {31'h0, take_branch_q}, 32'h0);
        checkOutput("rst_comb_take", 100, {31'h0, take_branch}, 32'h1);
        checkOutput("rst_comb_flags", 100, {24'h0, flags}, 32'h05);
        @(negedge CLK);
        rst = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("post_rst_take_q", 101, {31'h0, take_branch_q}, 32'h1);
        checkOutput("post_rst_flags_q", 101, {24'h0, flags_q}, 32'h05);

        // Not-taken bne must clear the registered decision on the next edge.
        applyStimulus(2'b01, 32'h1400_0000, 32'h9, 32'h9);
        @(posedge CLK);
        #1;
        checkOutput("bne_clears_take_q", 102, {31'h0, take_branch_q}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
